// File: rtl/key_hop_ctrl.sv
// key_hop_ctrl: converts a held USB arrow keycode into one-frame hop requests.
// frame_clk (VGA vsync) is synchronised into Clk and edge-detected into a
// single-cycle frame_tick; the hop FSM advances only on that tick.
// Optional feature: define KEY_HOP_AUTOREPEAT_EN to enable auto-repeat
// (first repeat after REPEAT_DELAY frames, then every REPEAT_RATE frames).
// Without it, hops fire only on a new press or a direction change.
module key_hop_ctrl #(
    parameter int REPEAT_DELAY = 15,
    parameter int REPEAT_RATE  = 6
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] keycode,
    input  logic        frame_clk,
    output logic        hop_up,
    output logic        hop_down,
    output logic        hop_left,
    output logic        hop_right,
    output logic [1:0]  last_dir,
    output logic [3:0]  dir_led
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_REPEAT
    } state_e;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_e;

    // Elaboration-time guard on the counter range (cnt is 6 bits).
    if (REPEAT_DELAY < 1 || REPEAT_DELAY > 63) begin : g_bad_delay
        $error("key_hop_ctrl: REPEAT_DELAY must be in 1..63");
    end
    if (REPEAT_RATE < 1 || REPEAT_RATE > 63) begin : g_bad_rate
        $error("key_hop_ctrl: REPEAT_RATE must be in 1..63");
    end

`ifdef KEY_HOP_AUTOREPEAT_EN
    localparam logic [5:0] DELAY_LAST = 6'(REPEAT_DELAY - 1);
    localparam logic [5:0] RATE_LAST  = 6'(REPEAT_RATE - 1);
`endif

    // Hop vector packing used internally: {up, down, left, right}.
    function automatic logic [3:0] hop_vec(input dir_e dir);
        case (dir)
            DIR_UP:   hop_vec = 4'b1000;
            DIR_DOWN: hop_vec = 4'b0100;
            DIR_LEFT: hop_vec = 4'b0010;
            default:  hop_vec = 4'b0001;
        endcase
    endfunction

    // LED packing: {left, up, down, right}.
    function automatic logic [3:0] led_vec(input dir_e dir);
        case (dir)
            DIR_UP:   led_vec = 4'b0100;
            DIR_DOWN: led_vec = 4'b0010;
            DIR_LEFT: led_vec = 4'b1000;
            default:  led_vec = 4'b0001;
        endcase
    endfunction

    // frame_clk synchroniser and edge-detect state
    logic       s1_q, s1_d;
    logic       s2_q, s2_d;
    logic       p_q, p_d;
    logic [1:0] fill_q, fill_d;
    logic       frame_tick;

    // hop FSM state and registered outputs
    state_e     state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    logic [3:0] hop_q, hop_d;
    dir_e       last_dir_q, last_dir_d;
    logic [3:0] led_q, led_d;

    // keycode decode
    logic       key_valid;
    dir_e       key_dir;

    // Decode the four arrow keycodes; anything else means no key.
    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        key_valid = 1'b1;
        key_dir   = DIR_UP;
        case (keycode)
            16'h0052: key_dir = DIR_UP;
            16'h0051: key_dir = DIR_DOWN;
            16'h0050: key_dir = DIR_LEFT;
            16'h004F: key_dir = DIR_RIGHT;
            default:  key_valid = 1'b0;
        endcase
    end

    // Synchroniser next state. The history flop p is held high until s2 carries
    // a genuine sample (two edges after reset), so a frame_clk already high at
    // reset release cannot produce a tick.
    always_comb begin
        s1_d   = frame_clk;
        s2_d   = s1_q;
        fill_d = {fill_q[0], 1'b1};
        p_d    = fill_q[1] ? s2_q : 1'b1;
    end

    assign frame_tick = s2_q & ~p_q;

    // Synchroniser registers.
    always_ff @(posedge Clk or posedge Reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (Reset) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            p_q    <= 1'b1;
            fill_q <= 2'b00;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            p_q    <= p_d;
            fill_q <= fill_d;
        end
    end

    // Hop FSM next state: everything changes only on frame_tick.
    always_comb begin
        logic emit;
        emit       = 1'b0;
        state_d    = state_q;
        cnt_d      = cnt_q;
        hop_d      = hop_q;
        last_dir_d = last_dir_q;
        led_d      = led_q;

        if (frame_tick) begin
            hop_d = 4'b0000;
            case (state_q)
                ST_IDLE: begin
                    if (key_valid) begin
                        emit    = 1'b1;
                        cnt_d   = 6'd0;
                        state_d = ST_HOLD;
                    end
                end
                default: begin
                    if (!key_valid) begin
                        cnt_d   = 6'd0;
                        state_d = ST_IDLE;
                    end else if (key_dir != last_dir_q) begin
                        emit    = 1'b1;
                        cnt_d   = 6'd0;
                        state_d = ST_HOLD;
                    end else begin
`ifdef KEY_HOP_AUTOREPEAT_EN
                        if (state_q == ST_HOLD) begin
                            if (cnt_q == DELAY_LAST) begin
                                emit    = 1'b1;
                                cnt_d   = 6'd0;
                                state_d = ST_REPEAT;
                            end else begin
                                cnt_d = cnt_q + 6'd1;
                            end
                        end else begin
                            if (cnt_q == RATE_LAST) begin
                                emit  = 1'b1;
                                cnt_d = 6'd0;
                            end else begin
                                cnt_d = cnt_q + 6'd1;
                            end
                        end
`else
                        cnt_d   = 6'd0;
                        state_d = ST_HOLD;
`endif
                    end
                end
            endcase

            if (emit) begin
                hop_d      = hop_vec(key_dir);
                last_dir_d = key_dir;
                led_d      = led_vec(key_dir);
            end
        end
    end

    // Hop FSM registers; all outputs come straight from these flops.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 6'd0;
            hop_q      <= 4'b0000;
            last_dir_q <= DIR_UP;
            led_q      <= 4'b0000;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hop_q      <= hop_d;
            last_dir_q <= last_dir_d;
            led_q      <= led_d;
        end
    end

    assign hop_up    = hop_q[3];
    assign hop_down  = hop_q[2];
    assign hop_left  = hop_q[1];
    assign hop_right = hop_q[0];
    assign last_dir  = last_dir_q;
    assign dir_led   = led_q;

endmodule

// File: tb/tb_key_hop_ctrl.sv
// Directed testbench for key_hop_ctrl. Expected auto-repeat behaviour follows
// whether KEY_HOP_AUTOREPEAT_EN is defined for the build.
module tb_key_hop_ctrl;

    localparam logic [3:0] H_NONE = 4'b0000;
    localparam logic [3:0] H_UP   = 4'b1000;
    localparam logic [3:0] H_DN   = 4'b0100;
    localparam logic [3:0] H_LT   = 4'b0010;
    localparam logic [3:0] H_RT   = 4'b0001;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] keycode = 16'h0000;
    logic        frame_clk = 1'b0;
    logic        hop_up, hop_down, hop_left, hop_right;
    logic [1:0]  last_dir;
    logic [3:0]  dir_led;
    logic [3:0]  hops;

    int checks = 0;
    int errors = 0;

    assign hops = {hop_up, hop_down, hop_left, hop_right};

    key_hop_ctrl #(
        .REPEAT_DELAY(15),
        .REPEAT_RATE (6)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .keycode  (keycode),
        .frame_clk(frame_clk),
        .hop_up   (hop_up),
        .hop_down (hop_down),
        .hop_left (hop_left),
        .hop_right(hop_right),
        .last_dir (last_dir),
        .dir_led  (dir_led)
    );

    always #10 Clk = ~Clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reset pulse with frame_clk low, then let the synchroniser prime.
    task automatic do_reset();
        @(negedge Clk);
        frame_clk = 1'b0;
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        repeat (4) @(negedge Clk);
    endtask

    // One vsync frame: high 5 cycles, low 6 cycles; ends on a falling Clk edge.
    task automatic frame();
        frame_clk = 1'b1;
        repeat (5) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (6) @(negedge Clk);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] exp;
        logic       seen;

        // Reset state
        repeat (2) @(negedge Clk);
        check("reset_hops", 16'(hops), 16'(H_NONE));
        check("reset_last_dir", 16'(last_dir), 16'd0);
        check("reset_dir_led", 16'(dir_led), 16'd0);
        Reset = 1'b0;
        repeat (4) @(negedge Clk);

        // Single up press then release
        keycode = 16'h0052;
        frame();
        check("up_hop", 16'(hops), 16'(H_UP));
        check("up_last_dir", 16'(last_dir), 16'd0);
        check("up_dir_led", 16'(dir_led), 16'b0100);
        keycode = 16'h0000;
        frame();
        check("up_release_hop", 16'(hops), 16'(H_NONE));
        check("up_release_last_dir", 16'(last_dir), 16'd0);
        check("up_release_dir_led", 16'(dir_led), 16'b0100);

        // Right held 30 frames
        do_reset();
        keycode = 16'h004F;
        for (int f = 0; f < 30; f++) begin
            frame();
            exp = (f == 0) ? H_RT : H_NONE;
`ifdef KEY_HOP_AUTOREPEAT_EN
            if (f >= 15 && ((f - 15) % 6) == 0) exp = H_RT;
`endif
            check($sformatf("hold_right_f%0d", f), 16'(hops), 16'(exp));
        end
        check("hold_right_last_dir", 16'(last_dir), 16'd3);
        check("hold_right_dir_led", 16'(dir_led), 16'b0001);
        keycode = 16'h0000;
        frame();
        check("hold_right_release", 16'(hops), 16'(H_NONE));

        // Left 3 frames then down: direction change restarts the hold
        do_reset();
        keycode = 16'h0050;
        for (int f = 0; f < 3; f++) begin
            frame();
            check($sformatf("left_f%0d", f), 16'(hops), 16'(f == 0 ? H_LT : H_NONE));
        end
        keycode = 16'h0051;
        frame();
        check("down_f3_hop", 16'(hops), 16'(H_DN));
        check("down_f3_last_dir", 16'(last_dir), 16'd1);
        check("down_f3_dir_led", 16'(dir_led), 16'b0010);
        for (int f = 4; f <= 18; f++) begin
            frame();
            exp = H_NONE;
`ifdef KEY_HOP_AUTOREPEAT_EN
            if (f == 18) exp = H_DN;
`endif
            check($sformatf("down_f%0d", f), 16'(hops), 16'(exp));
        end

        // frame_clk high across reset release, then latency of the next rise
        keycode = 16'h0000;
        @(negedge Clk);
        frame_clk = 1'b1;
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        keycode = 16'h0052;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge Clk);
            if (hops != H_NONE) seen = 1'b1;
        end
        check("no_tick_high_release", 16'(seen), 16'd0);
        frame_clk = 1'b0;
        repeat (5) @(negedge Clk);
        check("no_tick_after_low", 16'(hops), 16'(H_NONE));
        frame_clk = 1'b1;
        @(negedge Clk);
        check("lat_edge_k", 16'(hops), 16'(H_NONE));
        @(negedge Clk);
        check("lat_edge_k1", 16'(hops), 16'(H_NONE));
        @(negedge Clk);
        check("lat_edge_k2", 16'(hops), 16'(H_UP));
        repeat (2) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (6) @(negedge Clk);

        // Reset mid-hold / mid-repeat with the key still held
        do_reset();
        keycode = 16'h004F;
        for (int f = 0; f < 16; f++) frame();
`ifdef KEY_HOP_AUTOREPEAT_EN
        check("pre_reset_hop", 16'(hops), 16'(H_RT));
`else
        check("pre_reset_hop", 16'(hops), 16'(H_NONE));
`endif
        check("pre_reset_dir_led", 16'(dir_led), 16'b0001);
        #3;
        Reset = 1'b1;
        #1;
        check("async_reset_hops", 16'(hops), 16'(H_NONE));
        check("async_reset_last_dir", 16'(last_dir), 16'd0);
        check("async_reset_dir_led", 16'(dir_led), 16'd0);
        @(negedge Clk);
        Reset = 1'b0;
        repeat (4) @(negedge Clk);
        frame();
        check("post_reset_press", 16'(hops), 16'(H_RT));
        check("post_reset_last_dir", 16'(last_dir), 16'd3);
        for (int f = 1; f <= 6; f++) begin
            frame();
            check($sformatf("post_reset_hold_f%0d", f), 16'(hops), 16'(H_NONE));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_hop_ctrl.md
KEY_HOP_CTRL -- requirements
Module: key_hop_ctrl

Interface
REQ-001 SHALL have parameter REPEAT_DELAY, default 15, meaning frames a key must be held before the first auto-repeat hop (legal 1..63).
REQ-002 SHALL have parameter REPEAT_RATE, default 6, meaning frames between successive auto-repeat hops (legal 1..63).
REQ-003 SHALL have port Clk, input, 1, system clock (50 MHz); the block's only clock, all state on its rising edge.
REQ-004 SHALL have port Reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port keycode, input, 16, USB keycode from the Nios keycode PIO, synchronous to Clk.
REQ-006 SHALL have port frame_clk, input, 1, VGA vertical sync, asynchronous to the block; its rising edge marks a frame.
REQ-007 SHALL have ports hop_up, hop_down, hop_left, hop_right, output, 1 each, hop requests consumed by the frog at frame_clk rise.
REQ-008 SHALL have port last_dir, output, 2, last accepted direction (00 up, 01 down, 10 left, 11 right).
REQ-009 SHALL have port dir_led, output, 4, one-hot last direction {left,up,down,right} for LEDG[3:0].

Function
REQ-010 SHALL decode keycode 0x0052 up, 0x0051 down, 0x0050 left, 0x004F right; any other value, including 0x0000, is "no key".
REQ-011 SHALL pass frame_clk through two Clk flip-flops (s1, s2) plus a history flop p; frame_tick = s2 AND NOT p, high for exactly one Clk cycle per frame.
REQ-012 SHALL change hop_* and FSM state only on the Clk edge at which frame_tick is high, using keycode sampled at that same edge.
REQ-013 SHALL hold hop_* constant for a full frame: at most one hop_* high, and hop_* cleared at the next frame_tick unless a new hop is emitted.
REQ-014 SHALL implement FSM states IDLE, HOLD, REPEAT with a 6-bit frame counter cnt.
REQ-015 IDLE: on tick with a valid key SHALL emit that hop, set cnt=0, go HOLD; with no key SHALL emit nothing.
REQ-016 HOLD/REPEAT: on tick with no key SHALL emit nothing and go IDLE.
REQ-017 HOLD/REPEAT: on tick with a direction differing from last_dir SHALL emit the new hop, set cnt=0, go HOLD.
REQ-018 HOLD: on tick with the same key SHALL increment cnt; when cnt reaches REPEAT_DELAY-1 SHALL emit a hop, clear cnt, go REPEAT.
REQ-019 REPEAT: on tick with the same key SHALL increment cnt; when cnt reaches REPEAT_RATE-1 SHALL emit a hop and clear cnt.
REQ-020 SHALL update last_dir and dir_led on every emitted hop only; no-key frames leave them unchanged.
REQ-021 Latency: frame_clk high first sampled by s1 at edge k SHALL make frame_tick high in the cycle after edge k+1 and update hop_* at edge k+2.
REQ-022 frame_clk pulses narrower than one Clk period may be missed; the block SHALL NOT generate more than one tick per captured rising edge.

Reset
REQ-023 Reset high SHALL immediately force hop_*=0, last_dir=00, dir_led=0000, cnt=0, state IDLE, s1=s2=0, p=1.
REQ-024 After Reset deasserts, no frame_tick SHALL occur until frame_clk has been sampled low then high (no spurious tick if frame_clk is high at release).
REQ-025 Reset mid-hold SHALL discard the hold; a key still held after reset is treated as a new press at the next valid tick.

Configuration
REQ-026 Macro KEY_HOP_AUTOREPEAT_EN defined: REQ-018/REQ-019 auto-repeat behaviour active.
REQ-027 Macro KEY_HOP_AUTOREPEAT_EN undefined: HOLD never transitions to REPEAT, cnt is held at 0, and hops are emitted only on new press or direction change.

Verification
REQ-028 Reset, keycode=0x0052 held across 1 tick then 0x0000 -> hop_up=1 for exactly one frame, last_dir=00, dir_led=0100.
REQ-029 Macro defined, 0x004F held 30 frames, defaults -> hops at frames 0, 15, 21, 27; hop_right only, dir_led=0001.
REQ-030 Macro undefined, 0x004F held 30 frames -> single hop at frame 0 only.
REQ-031 0x0050 held 3 frames then 0x0051 -> hop_left at frame 0, hop_down at frame 3, last_dir=01, cnt restarted.
REQ-032 frame_clk high while Reset deasserts -> no hop until next low-to-high; then hop_* updates exactly two Clk edges after s1 captures high.
REQ-033 Reset asserted mid-REPEAT with key held -> outputs zero asynchronously; after release, first tick emits hop and enters HOLD.
